// File: rtl/fog_mod_gen.sv
// fog_mod_gen: square-wave bias-modulation generator for the FOG closed loop.
// The DAC word is a wrapping serrodyne ramp plus the modulation level of the
// current half. o_status / o_trig give the error-signal generator its
// demodulation timing.
// Optional build macro: DAC_SAT_EN. When it is defined, the final
// ramp+level sum saturates instead of wrapping. The ramp itself always wraps.
module fog_mod_gen #(
  parameter int DAC_BIT  = 16,
  parameter int MIN_HALF = 2
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_en,
  input  logic [31:0]               i_half_period,
  input  logic signed [DAC_BIT-1:0] i_mod_amp_h,
  input  logic signed [DAC_BIT-1:0] i_mod_amp_l,
  input  logic signed [31:0]        i_step,
  input  logic                      i_step_sync,
  output logic                      o_status,
  output logic                      o_trig,
  output logic signed [DAC_BIT-1:0] o_dac,
  output logic signed [DAC_BIT-1:0] o_ramp,
  output logic [1:0]                o_cstate
);

  typedef enum logic [1:0] {IDLE = 2'd0, HIGH = 2'd1, LOW = 2'd2} state_t;

  localparam logic [31:0] MIN_HALF_W = 32'(MIN_HALF);

  // Registered inputs (one cycle of input latency)
  logic               r_en;
  logic               r_step_sync;
  logic [DAC_BIT-1:0] r_step;

  // Core state
  state_t             r_state;
  logic [31:0]        r_cnt;
  logic [31:0]        r_half;
  logic [DAC_BIT-1:0] r_amp_h;
  logic [DAC_BIT-1:0] r_amp_l;
  logic [DAC_BIT-1:0] r_ramp;
  logic               r_status;
  logic               r_trig;
  logic [DAC_BIT-1:0] r_dac;

  // Next-state wires
  state_t             w_state_nxt;
  logic [31:0]        w_cnt_nxt;
  logic               w_latch;
  logic               w_status_nxt;
  logic               w_trig_nxt;
  logic [31:0]        w_half_in;
  logic [31:0]        w_half_nxt;
  logic [DAC_BIT-1:0] w_amp_h_nxt;
  logic [DAC_BIT-1:0] w_amp_l_nxt;
  logic [DAC_BIT-1:0] w_ramp_nxt;
  logic [DAC_BIT-1:0] w_lvl;
  logic [DAC_BIT-1:0] w_dac_nxt;

  // Only the low DAC_BIT bits of the step matter; the upper bits are dropped.
  logic w_unused_step;
  assign w_unused_step = ^i_step[31:DAC_BIT];

  // Register the enable, the step-sync pulse and the step value
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_en        <= 1'b0;
      r_step_sync <= 1'b0;
      r_step      <= '0;
    end else begin
      r_en        <= i_en;
      r_step_sync <= i_step_sync;
      r_step      <= i_step[DAC_BIT-1:0];
    end
  end

  // Half-periods shorter than MIN_HALF are clamped up to MIN_HALF
  assign w_half_in = (i_half_period < MIN_HALF_W) ? MIN_HALF_W : i_half_period;

  // Next-state, counter and trigger decisions
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_latch      = 1'b0;
    w_status_nxt = r_status;
    w_trig_nxt   = 1'b0;
    case (r_state)
      IDLE: begin
        w_status_nxt = 1'b0;
        if (r_en) begin
          w_latch      = 1'b1;
          w_cnt_nxt    = w_half_in - 32'd1;
          w_state_nxt  = HIGH;
          w_status_nxt = 1'b1;
          w_trig_nxt   = 1'b1;
        end
      end
      HIGH: begin
        if (r_cnt == 32'd0) begin
          w_cnt_nxt    = r_half - 32'd1;
          w_state_nxt  = LOW;
          w_status_nxt = 1'b0;
          w_trig_nxt   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 32'd1;
        end
      end
      LOW: begin
        if (r_cnt != 32'd0) begin
          w_cnt_nxt = r_cnt - 32'd1;
        end else if (r_en) begin
          // A full period ends here, so new settings are latched only now.
          w_latch      = 1'b1;
          w_cnt_nxt    = w_half_in - 32'd1;
          w_state_nxt  = HIGH;
          w_status_nxt = 1'b1;
          w_trig_nxt   = 1'b1;
        end else begin
          w_cnt_nxt    = 32'd0;
          w_state_nxt  = IDLE;
          w_status_nxt = 1'b0;
        end
      end
      default: begin
        w_cnt_nxt    = 32'd0;
        w_state_nxt  = IDLE;
        w_status_nxt = 1'b0;
      end
    endcase
  end

  assign w_half_nxt  = w_latch ? w_half_in   : r_half;
  assign w_amp_h_nxt = w_latch ? i_mod_amp_h : r_amp_h;
  assign w_amp_l_nxt = w_latch ? i_mod_amp_l : r_amp_l;
  assign w_ramp_nxt  = r_step_sync ? (r_ramp + r_step) : r_ramp;

  // Level for the half being entered; IDLE carries no modulation
  always_comb begin
    w_lvl = '0;
    if (w_state_nxt == HIGH)     w_lvl = w_amp_h_nxt;
    else if (w_state_nxt == LOW) w_lvl = w_amp_l_nxt;
  end

`ifdef DAC_SAT_EN
  // Compute the sum one bit wider, then clamp it to the signed DAC range
  logic [DAC_BIT:0] w_sum;
  assign w_sum = {w_ramp_nxt[DAC_BIT-1], w_ramp_nxt} + {w_lvl[DAC_BIT-1], w_lvl};
  always_comb begin
    w_dac_nxt = w_sum[DAC_BIT-1:0];
    if (w_sum[DAC_BIT] != w_sum[DAC_BIT-1])
      w_dac_nxt = w_sum[DAC_BIT] ? {1'b1, {(DAC_BIT-1){1'b0}}}
                                 : {1'b0, {(DAC_BIT-1){1'b1}}};
  end
`else
  // Plain modulo-2^DAC_BIT sum
  assign w_dac_nxt = w_ramp_nxt + w_lvl;
`endif

  // State, latched settings, ramp and output registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= IDLE;
      r_cnt    <= 32'd0;
      r_half   <= MIN_HALF_W;
      r_amp_h  <= '0;
      r_amp_l  <= '0;
      r_ramp   <= '0;
      r_status <= 1'b0;
      r_trig   <= 1'b0;
      r_dac    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_half   <= w_half_nxt;
      r_amp_h  <= w_amp_h_nxt;
      r_amp_l  <= w_amp_l_nxt;
      r_ramp   <= w_ramp_nxt;
      r_status <= w_status_nxt;
      r_trig   <= w_trig_nxt;
      r_dac    <= w_dac_nxt;
    end
  end

  assign o_status = r_status;
  assign o_trig   = r_trig;
  assign o_dac    = r_dac;
  assign o_ramp   = r_ramp;
  assign o_cstate = r_state;

endmodule
